// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and alignment check
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL  access size encodings
//   state_t                         arbiter sequencer states
//   misaligned(addr_lo, size)       1 when the access cannot be serviced
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Only the two low address bits matter for natural alignment.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side request/response bundle
// Signals:
//   req, we, addr, wdata, size     request fields, driven by the requester
//   gnt                            one-cycle accept pulse
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion with load data / error
// Modports: master = requester, slave = arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic              gnt;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req, we, addr, wdata, size,
    input  gnt, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req, we, addr, wdata, size,
    output gnt, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte-lane extraction for loads and lane merge for stores
// Ports:
//   i_addr_lo     byte offset within the word
//   i_size        access size encoding
//   i_rd_word     word currently read from memory (load source)
//   i_old_word    previously captured word (store merge base)
//   i_wdata       right-aligned store data
//   o_load_data   selected lane(s), zero-extended
//   o_store_word  old word with the addressed lane(s) replaced
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [4:0] w_bit_base;

  assign w_bit_base = {i_addr_lo, 3'b000};

  always_comb begin
    o_load_data = '0;
    case (i_size)
      SZ_BYTE: o_load_data = {24'h0, i_rd_word[w_bit_base +: 8]};
      SZ_HALF: o_load_data = {16'h0, (i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0])};
      SZ_WORD: o_load_data = i_rd_word;
      default: o_load_data = '0;
    endcase
  end

  always_comb begin
    o_store_word = i_old_word;
    case (i_size)
      SZ_BYTE: o_store_word[w_bit_base +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
        else              o_store_word[15:0]  = i_wdata[15:0];
      end
      SZ_WORD: o_store_word = i_wdata;
      default: o_store_word = i_old_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-requester sequencer for a word-wide data memory
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   req0, req1              requester bundles (slave side)
//   o_mem_address           word-aligned memory address
//   o_mem_write_data        word to write
//   o_mem_write_enable      write strobe (memory writes on the clock edge)
//   o_mem_read_enable       read strobe
//   i_mem_read_data         combinational read word from o_mem_address
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dmem_arbiter_if.slave     req0,
  dmem_arbiter_if.slave     req1,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write_enable,
  output logic              o_mem_read_enable,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_old;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rsp0;
  logic              w_rsp1;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_size;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_err;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_store_word;

  // Fields of whichever requester wins this cycle; w_gnt1 doubles as the owner id.
  always_comb begin
    w_sel_we    = req0.we;
    w_sel_addr  = req0.addr;
    w_sel_size  = req0.size;
    w_sel_wdata = req0.wdata;
    if (w_gnt1) begin
      w_sel_we    = req1.we;
      w_sel_addr  = req1.addr;
      w_sel_size  = req1.size;
      w_sel_wdata = req1.wdata;
    end
  end

  assign w_sel_err = misaligned(w_sel_addr[1:0], w_sel_size);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state       = r_state;
    w_gnt0             = 1'b0;
    w_gnt1             = 1'b0;
    w_rsp0             = 1'b0;
    w_rsp1             = 1'b0;
    o_mem_read_enable  = 1'b0;
    o_mem_write_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie, r_last_grant==1 means requester 0 is due.
        if (req0.req && (!req1.req || r_last_grant)) w_gnt0 = 1'b1;
        else if (req1.req)                          w_gnt1 = 1'b1;
        if (w_gnt0 || w_gnt1) begin
          if (w_sel_err)                w_next_state = S_RESP;
          else if (!w_sel_we)           w_next_state = S_READ;
          else if (w_sel_size == SZ_WORD) w_next_state = S_WRITE;
          else                          w_next_state = S_READ;
        end
      end
      S_READ: begin
        o_mem_read_enable = 1'b1;
        w_next_state      = r_we ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        o_mem_write_enable = 1'b1;
        w_next_state       = S_RESP;
      end
      S_RESP: begin
        w_rsp0       = ~r_owner;
        w_rsp1       = r_owner;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // Reset abandons whatever is in flight, including a write due this cycle.
    if (i_rst) begin
      w_gnt0             = 1'b0;
      w_gnt1             = 1'b0;
      w_rsp0             = 1'b0;
      w_rsp1             = 1'b0;
      o_mem_read_enable  = 1'b0;
      o_mem_write_enable = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_size       <= SZ_BYTE;
      r_wdata      <= '0;
      r_old        <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last_grant <= w_gnt1;
        r_owner      <= w_gnt1;
        r_we         <= w_sel_we;
        r_addr       <= w_sel_addr;
        r_size       <= w_sel_size;
        r_wdata      <= w_sel_wdata;
        r_err        <= w_sel_err;
        r_rdata      <= '0;
      end
      if (r_state == S_READ) begin
        r_old <= i_mem_read_data;
        if (!r_we) r_rdata <= w_load_data;
      end
    end
  end

  dmem_lane_unit u_lane (
    .i_addr_lo    (r_addr[1:0]),
    .i_size       (r_size),
    .i_rd_word    (i_mem_read_data),
    .i_old_word   (r_old),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  assign o_mem_address    = i_rst ? '0 : {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_write_data = o_mem_write_enable ? w_store_word : '0;

  assign req0.gnt       = w_gnt0;
  assign req1.gnt       = w_gnt1;
  assign req0.rsp_valid = w_rsp0;
  assign req1.rsp_valid = w_rsp1;
  assign req0.rsp_rdata = i_rst ? '0 : r_rdata;
  assign req1.rsp_rdata = i_rst ? '0 : r_rdata;
  assign req0.rsp_err   = i_rst ? 1'b0 : r_err;
  assign req1.rsp_err   = i_rst ? 1'b0 : r_err;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port word-wide DataMemory. Shares the memory between requester 0 (core load/store path) and requester 1 (program loader/debug port), with round-robin arbitration. Performs byte and halfword stores as read-modify-write and byte/halfword loads as lane extraction. Only one access is in flight at a time; every granted request gets exactly one response pulse.

Parameters:
ADDR_W, 32, byte-address width of requester and memory address buses
DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req0 / req1  input  1  access request; held high until gntN
we0 / we1  input  1  1=store, 0=load
addr0 / addr1  input  ADDR_W  byte address
wdata0 / wdata1  input  DATA_W  store data, right-aligned for sub-word stores
size0 / size1  input  2  00 byte, 01 half, 10 word, 11 illegal
gnt0 / gnt1  output  1  one-cycle pulse: request accepted, fields latched
rsp_valid0 / rsp_valid1  output  1  one-cycle completion pulse to owning requester
rsp_rdata  output  DATA_W  load data, zero-extended, valid with rsp_validN
rsp_err  output  1  misaligned/illegal access, valid with rsp_validN
mem_address  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_write_data  output  DATA_W  word written to memory
mem_write_enable  output  1  memory write strobe (memory writes on clk edge)
mem_read_enable  output  1  memory read strobe
mem_read_data  input  DATA_W  memory read word, combinational from mem_address

Behaviour:
- Clock is clk; reset is rst: synchronous, active-high. Reset returns the FSM to IDLE and clears last_grant to 1, so requester 0 wins the first tie. It also drives all outputs to 0: gnt, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_write_enable and mem_read_enable.
- Reset mid-operation: the access is abandoned. No response is issued and no memory write occurs in or after the reset cycle.
- FSM states: IDLE, READ, WRITE, RESP. Memory strobes are Moore outputs decoded from state.
- IDLE: if any req is high, pick a winner, pulse its gnt in that cycle, latch we/addr/size/wdata and the owner, and set last_grant=owner.
  - Both requests high: grant the requester that is not last_grant.
  - Single request: grant it regardless of last_grant.
- Alignment check at grant:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 is an error.
  - Error goes IDLE->RESP with rsp_err=1 and rsp_rdata=0. No memory strobe is issued.
- Load: IDLE->READ->RESP.
  - In READ, mem_read_enable=1 and the lane is captured from mem_read_data at the edge.
  - Byte: mem_read_data[8*a+7:8*a] with a=addr[1:0]. Half: the half selected by addr[1]. Result is zero-extended.
- Word store: IDLE->WRITE->RESP. In WRITE, mem_write_enable=1 and mem_write_data=wdata.
- Sub-word store: IDLE->READ->WRITE->RESP.
  - READ captures the old word.
  - WRITE writes the old word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- RESP: rsp_validN=1 for the owner only, for one cycle, then ->IDLE. No grant is issued in RESP, so the earliest next grant is the cycle after RESP.
- Latency from the grant cycle T: error rsp at T+1; load or word store at T+2; sub-word store at T+3.
- mem_address is held constant from grant through WRITE/RESP.
- Requester-side rules:
  - A req that is dropped before its grant is never serviced.
  - Input changes after gnt are ignored.
  - A req still high after gnt is treated as a new request.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - the state enum
  - function misaligned(addr, size)
- Sub-module dmem_lane_unit (combinational) holds:
  - load lane extraction/zero-extension
  - store lane merge (old word, wdata, addr[1:0], size -> new word)
- The arbiter FSM remains in dmem_arbiter.

Test Plan:
- Word store then load:
  - req0 we=1 addr=0x4 size=10 wdata=0xDEADBEEF -> gnt0 at T, mem_write_enable at T+1, rsp_valid0 at T+2.
  - Load of 0x4 -> rsp_rdata=0xDEADBEEF.
- Byte RMW:
  - Memory 0x8=0xCAFEBABE; store byte 0x11 at 0xA -> READ, WRITE, rsp at T+3; memory 0x8=0xCA11BABE.
  - Half load at 0xA -> rsp_rdata=0x0000CA11.
- Round-robin:
  - req0 and req1 high together, repeatedly, from reset -> grants 0,1,0,1.
  - Each rsp_valid goes only to the owner; no grant during RESP.
- Misalignment:
  - Word load at 0x6 -> rsp_err=1, rsp_rdata=0 at T+1; mem_read_enable and mem_write_enable never asserted.
  - size=11 at 0x0 -> same response.
- Reset mid-RMW:
  - Assert rst in the READ cycle of a byte store to 0x4 -> no rsp_valid, no mem_write_enable.
  - Memory 0x4 unchanged; next req0 granted first.
- Dropped request:
  - req1 pulses only while a req0 access is busy -> never granted, no rsp_valid1.
